// File: rtl/rv64g_l1_evict_unit.sv
// L1 victim eviction: reads the victim line out of the arrays and releases it to L2
// over TL-C, then writes the way's state to N after the L2's ReleaseAck on TL-D.
module rv64g_l1_evict_unit #(
    parameter int unsigned SETS     = 32,
    parameter int unsigned WAYS     = 8,
    parameter int unsigned INDEX_W  = 5,
    parameter int unsigned TAG_W    = 53,
    parameter int unsigned SOURCE_W = 4,
    parameter logic [SOURCE_W-1:0] SOURCE_ID = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                evict_valid_i,
    output logic                evict_ready_o,
    input  logic [INDEX_W-1:0]  evict_index_i,
    input  logic [2:0]          evict_way_i,
    output logic                evict_done_o,
    output logic                evict_dirty_o,
    output logic [INDEX_W-1:0]  arr_index_o,
    output logic [2:0]          arr_way_sel_o,
    output logic [2:0]          arr_word_sel_o,
    output logic                arr_write_en_o,
    output logic [7:0]          arr_be_o,
    output logic [1:0]          arr_state_o,
    output logic [TAG_W-1:0]    arr_tag_o,
    output logic [63:0]         arr_wdata_o,
    input  logic [63:0]         arr_rdata_i,
    input  logic [TAG_W-1:0]    arr_tag_i,
    input  logic [1:0]          arr_state_i,
    output logic                c_valid_o,
    input  logic                c_ready_i,
    output logic [2:0]          c_opcode_o,
    output logic [2:0]          c_param_o,
    output logic [3:0]          c_size_o,
    output logic [SOURCE_W-1:0] c_source_o,
    output logic [63:0]         c_address_o,
    output logic [63:0]         c_data_o,
    input  logic                d_valid_i,
    output logic                d_ready_o,
    input  logic [2:0]          d_opcode_i
);

    localparam int unsigned SET_W = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [1:0] ST_N  = 2'd0;
    localparam logic [1:0] ST_B  = 2'd1;
    localparam logic [1:0] ST_TT = 2'd3;

    localparam logic [2:0] OP_RELEASE      = 3'd6;
    localparam logic [2:0] OP_RELEASE_DATA = 3'd7;
    localparam logic [2:0] OP_RELEASE_ACK  = 3'd6;
    localparam logic [2:0] PRM_TTON        = 3'd1;
    localparam logic [2:0] PRM_BTON        = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_SEND,
        S_WAIT_ACK,
        S_INVAL
    } state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   idx_q;
    logic [WAY_W-1:0]   way_q;
    logic [TAG_W-1:0]   tag_q;
    logic               dirty_q;
    logic               bton_q;
    logic [2:0]         beat_q;
    logic               last_beat;

    // ReleaseData runs beats 0..7; a plain Release is the single beat 0.
    assign last_beat = dirty_q ? (beat_q == 3'd7) : 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            way_q   <= '0;
            tag_q   <= '0;
            dirty_q <= 1'b0;
            bton_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (evict_valid_i) begin
                        idx_q <= evict_index_i[SET_W-1:0];
                        way_q <= evict_way_i[WAY_W-1:0];
                    end
                end
                S_LOOKUP: begin
                    tag_q   <= arr_tag_i;
                    dirty_q <= (arr_state_i == ST_TT);
                    bton_q  <= (arr_state_i == ST_B);
                    beat_q  <= '0;
                end
                S_SEND: begin
                    if (c_ready_i) begin
                        beat_q <= last_beat ? 3'd0 : beat_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d        = state_q;
        evict_ready_o  = 1'b0;
        evict_done_o   = 1'b0;
        evict_dirty_o  = 1'b0;
        c_valid_o      = 1'b0;
        c_opcode_o     = 3'd0;
        c_param_o      = 3'd0;
        c_address_o    = 64'd0;
        c_data_o       = 64'd0;
        arr_word_sel_o = 3'd0;
        arr_write_en_o = 1'b0;
        arr_tag_o      = '0;
        d_ready_o      = 1'b0;
        case (state_q)
            S_IDLE: begin
                evict_ready_o = 1'b1;
                if (evict_valid_i) state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (arr_state_i == ST_N) begin
                    evict_done_o = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                c_valid_o      = 1'b1;
                c_opcode_o     = dirty_q ? OP_RELEASE_DATA : OP_RELEASE;
                c_param_o      = bton_q ? PRM_BTON : PRM_TTON;
                c_address_o    = 64'({tag_q, INDEX_W'(idx_q), 6'b0});
                c_data_o       = dirty_q ? arr_rdata_i : 64'd0;
                arr_word_sel_o = beat_q;
                if (c_ready_i && last_beat) state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                d_ready_o = d_valid_i && (d_opcode_i == OP_RELEASE_ACK);
                if (d_ready_o) state_d = S_INVAL;
            end
            S_INVAL: begin
                arr_write_en_o = 1'b1;
                arr_tag_o      = tag_q;
                evict_done_o   = 1'b1;
                evict_dirty_o  = dirty_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign arr_index_o   = INDEX_W'(idx_q);
    assign arr_way_sel_o = 3'(way_q);
    assign arr_be_o      = 8'h00;
    assign arr_state_o   = ST_N;
    assign arr_wdata_o   = 64'd0;
    assign c_size_o      = 4'd6;
    assign c_source_o    = SOURCE_ID;

endmodule

// File: tb/tb_rv64g_l1_evict_unit.sv
// Bench for rv64g_l1_evict_unit: table vectors, hand sequences for stalls and reset,
// and random evictions checked against a message/timing model of the eviction.
module tb_rv64g_l1_evict_unit;
    localparam int INDEX_W  = 5;
    localparam int TAG_W    = 53;
    localparam int SOURCE_W = 4;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                evict_valid_i, evict_ready_o;
    logic [INDEX_W-1:0]  evict_index_i;
    logic [2:0]          evict_way_i;
    logic                evict_done_o, evict_dirty_o;
    logic [INDEX_W-1:0]  arr_index_o;
    logic [2:0]          arr_way_sel_o, arr_word_sel_o;
    logic                arr_write_en_o;
    logic [7:0]          arr_be_o;
    logic [1:0]          arr_state_o;
    logic [TAG_W-1:0]    arr_tag_o;
    logic [63:0]         arr_wdata_o, arr_rdata_i;
    logic [TAG_W-1:0]    arr_tag_i;
    logic [1:0]          arr_state_i;
    logic                c_valid_o, c_ready_i;
    logic [2:0]          c_opcode_o, c_param_o;
    logic [3:0]          c_size_o;
    logic [SOURCE_W-1:0] c_source_o;
    logic [63:0]         c_address_o, c_data_o;
    logic                d_valid_i, d_ready_o;
    logic [2:0]          d_opcode_i;

    always #5 clk_i = ~clk_i;

    rv64g_l1_evict_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .evict_valid_i(evict_valid_i), .evict_ready_o(evict_ready_o),
        .evict_index_i(evict_index_i), .evict_way_i(evict_way_i),
        .evict_done_o(evict_done_o), .evict_dirty_o(evict_dirty_o),
        .arr_index_o(arr_index_o), .arr_way_sel_o(arr_way_sel_o),
        .arr_word_sel_o(arr_word_sel_o), .arr_write_en_o(arr_write_en_o),
        .arr_be_o(arr_be_o), .arr_state_o(arr_state_o), .arr_tag_o(arr_tag_o),
        .arr_wdata_o(arr_wdata_o), .arr_rdata_i(arr_rdata_i),
        .arr_tag_i(arr_tag_i), .arr_state_i(arr_state_i),
        .c_valid_o(c_valid_o), .c_ready_i(c_ready_i),
        .c_opcode_o(c_opcode_o), .c_param_o(c_param_o), .c_size_o(c_size_o),
        .c_source_o(c_source_o), .c_address_o(c_address_o), .c_data_o(c_data_o),
        .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_opcode_i(d_opcode_i)
    );

    // Behavioural L1 arrays, read combinationally through the DUT's array port.
    logic [63:0]      mem_data  [8][32][8];
    logic [TAG_W-1:0] mem_tag   [8][32];
    logic [1:0]       mem_state [8][32];
    bit               sched     [80];

    assign arr_rdata_i = mem_data[arr_way_sel_o][arr_index_o][arr_word_sel_o];
    assign arr_tag_i   = mem_tag[arr_way_sel_o][arr_index_o];
    assign arr_state_i = mem_state[arr_way_sel_o][arr_index_o];

    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0;

    typedef struct {
        int idx; int way; logic [1:0] st; logic [TAG_W-1:0] tag;
        int rmode; int ack_at; bit bad;
        int e_op; int e_param; int e_beats; bit e_dirty;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " ready"}, evict_ready_o, 1);
        chk({nm, " strobes"}, {c_valid_o, arr_write_en_o, evict_done_o, evict_dirty_o, d_ready_o}, 0);
        chk({nm, " c payload"}, {c_opcode_o, c_param_o, c_address_o}, 0);
        chk({nm, " c data"}, c_data_o, 0);
        chk({nm, " c const"}, {c_size_o, c_source_o}, {4'd6, 4'd0});
        chk({nm, " arr port"}, {arr_index_o, arr_way_sel_o, arr_word_sel_o, arr_tag_o, arr_be_o}, 0);
    endtask

    // Message shape of a release, straight from the coherence state of the victim.
    function automatic void spec_msg(input logic [1:0] st, output int op, output int prm,
                                     output int nb, output bit dty);
        case (st)
            2'd3:    begin op = 7; prm = 1; nb = 8; dty = 1; end
            2'd2:    begin op = 6; prm = 1; nb = 1; dty = 0; end
            2'd1:    begin op = 6; prm = 2; nb = 1; dty = 0; end
            default: begin op = 0; prm = 0; nb = 0; dty = 0; end
        endcase
    endfunction

    // Completion cycle counted from the accepting edge, given the ready schedule
    // and the cycle from which a usable ReleaseAck is on the D channel.
    function automatic int model_done(input int nb, input int ack_at, input bit bad);
        int k, left, a, first_ok;
        if (nb == 0) return 1;
        k = 2; left = nb;
        while (k < 79) begin
            if (sched[k]) begin
                left--;
                if (left == 0) break;
            end
            k++;
        end
        first_ok = bad ? ack_at + 3 : ack_at;
        a = (k + 1 > first_ok) ? k + 1 : first_ok;
        return a + 1;
    endfunction

    task automatic run_evict(input int idx, input int way, input int rmode, input int ack_at,
                             input bit bad, input int e_op, input int e_param, input int e_beats,
                             input bit e_dirty, input string nm);
        logic [TAG_W-1:0] otag;
        logic [63:0] exp_addr, exp_data;
        logic [4:0] idx5;
        int e_done, nbeats, done_k, writes;
        bit got_dirty, saw_valid, prev_stall, wr_pend;
        logic [63:0] p_addr, p_data;
        logic [8:0] p_ctl;
        otag = mem_tag[way][idx];
        idx5 = 5'(idx);
        exp_addr = {otag, idx5, 6'b0};
        for (int k = 0; k < 80; k++)
            sched[k] = (rmode == 0) ? 1'b1 : (rmode == 1) ? bit'(k % 2 == 1)
                     : (k >= 40) ? 1'b1 : bit'($urandom_range(0, 1));
        e_done = model_done(e_beats, ack_at, bad);
        nbeats = 0; done_k = -1; writes = 0; got_dirty = 0; saw_valid = 0;
        prev_stall = 0; wr_pend = 0; p_addr = 0; p_data = 0; p_ctl = 0;

        @(negedge clk_i);
        c_ready_i = 0; d_valid_i = 0; d_opcode_i = 0;
        evict_valid_i = 1; evict_index_i = idx5; evict_way_i = 3'(way);
        #1;
        chk({nm, " accept ready"}, evict_ready_o, 1);
        @(posedge clk_i);
        for (int k = 1; k < 80 && done_k < 0; k++) begin
            @(negedge clk_i);
            evict_valid_i = 0;
            c_ready_i  = sched[k];
            d_valid_i  = (k >= ack_at);
            d_opcode_i = (bad && k < ack_at + 3) ? 3'd1 : 3'd6;
            #1;
            if (k == 1) chk({nm, " lookup addr"}, {arr_index_o, arr_way_sel_o}, {idx5, 3'(way)});
            if (d_valid_i && d_opcode_i == 3'd1) chk({nm, " d_ready on non-ack"}, d_ready_o, 0);
            if (c_valid_o) begin
                saw_valid = 1;
                if (prev_stall) begin
                    chk($sformatf("%s stall addr/data b%0d", nm, nbeats), {c_address_o, c_data_o}, {p_addr, p_data});
                    chk($sformatf("%s stall ctl b%0d", nm, nbeats), {c_opcode_o, c_param_o, arr_word_sel_o}, p_ctl);
                end
                if (c_ready_i) begin
                    exp_data = (e_dirty && nbeats < 8) ? mem_data[way][idx][nbeats] : 64'd0;
                    chk($sformatf("%s b%0d op/param/word", nm, nbeats),
                        {c_opcode_o, c_param_o, arr_word_sel_o}, {3'(e_op), 3'(e_param), 3'(nbeats)});
                    chk($sformatf("%s b%0d addr", nm, nbeats), c_address_o, exp_addr);
                    chk($sformatf("%s b%0d data", nm, nbeats), c_data_o, exp_data);
                    chk($sformatf("%s b%0d size/source", nm, nbeats), {c_size_o, c_source_o}, {4'd6, 4'd0});
                    nbeats++;
                end
                prev_stall = !c_ready_i;
                p_addr = c_address_o; p_data = c_data_o;
                p_ctl = {c_opcode_o, c_param_o, arr_word_sel_o};
            end else begin
                prev_stall = 0;
            end
            if (arr_write_en_o) begin
                chk({nm, " inval write"}, {arr_state_o, arr_tag_o, arr_be_o, arr_index_o, arr_way_sel_o},
                    {2'd0, otag, 8'h00, idx5, 3'(way)});
                chk({nm, " inval wdata"}, arr_wdata_o, 0);
                writes++;
                wr_pend = 1;
            end
            if (evict_done_o) begin
                done_k = k;
                got_dirty = evict_dirty_o;
            end
            @(posedge clk_i);
            if (wr_pend) begin
                mem_state[way][idx] = 2'd0;
                wr_count++;
                wr_pend = 0;
            end
        end
        c_ready_i = 0; d_valid_i = 0;
        chk({nm, " done cycle"}, done_k, e_done);
        chk({nm, " dirty"}, got_dirty, e_dirty);
        chk({nm, " beat count"}, nbeats, e_beats);
        chk({nm, " any c_valid"}, saw_valid, e_beats > 0);
        chk({nm, " writes"}, writes, (e_beats > 0) ? 1 : 0);
        chk({nm, " final state"}, mem_state[way][idx], 2'd0);
    endtask

    initial begin
        int op, prm, nb;
        bit dty;
        rst_ni = 0; evict_valid_i = 0; evict_index_i = 0; evict_way_i = 0;
        c_ready_i = 0; d_valid_i = 0; d_opcode_i = 0;
        for (int w = 0; w < 8; w++)
            for (int s = 0; s < 32; s++) begin
                mem_tag[w][s]   = TAG_W'({$urandom, $urandom});
                mem_state[w][s] = 2'($urandom_range(0, 3));
                for (int i = 0; i < 8; i++) mem_data[w][s][i] = {$urandom, $urandom};
            end

        vecs[0] = '{5,  3, 2'd3, 53'h1234,   0, 10, 0, 7, 1, 8, 1};
        vecs[1] = '{7,  0, 2'd2, 53'habcde,  0, 4,  0, 6, 1, 1, 0};
        vecs[2] = '{12, 5, 2'd1, 53'h55,     0, 2,  0, 6, 2, 1, 0};
        vecs[3] = '{20, 7, 2'd0, 53'h77,     0, 1,  0, 0, 0, 0, 0};
        vecs[4] = '{31, 1, 2'd3, 53'h1abcd,  1, 3,  0, 7, 1, 8, 1};
        vecs[5] = '{0,  2, 2'd2, 53'h9,      0, 3,  1, 6, 1, 1, 0};
        vecs[6] = '{4,  4, 2'd3, 53'hfff,    0, 5,  1, 7, 1, 8, 1};
        for (int i = 0; i < 8; i++) mem_data[3][5][i] = 64'h100 + 64'(i);

        repeat (3) @(negedge clk_i);
        #1 chk_reset_vals("reset");
        @(negedge clk_i);
        rst_ni = 1;

        for (int v = 0; v < 7; v++) begin
            mem_tag[vecs[v].way][vecs[v].idx]   = vecs[v].tag;
            mem_state[vecs[v].way][vecs[v].idx] = vecs[v].st;
            run_evict(vecs[v].idx, vecs[v].way, vecs[v].rmode, vecs[v].ack_at, vecs[v].bad,
                      vecs[v].e_op, vecs[v].e_param, vecs[v].e_beats, vecs[v].e_dirty,
                      $sformatf("vec%0d", v));
        end

        // Reset pulsed while beat 4 of a ReleaseData is on the C channel.
        mem_state[6][9] = 2'd3;
        mem_tag[6][9]   = 53'h2468;
        begin
            int wr_before;
            wr_before = wr_count;
            @(negedge clk_i);
            evict_valid_i = 1; evict_index_i = 5'd9; evict_way_i = 3'd6;
            @(posedge clk_i);
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk_i);
                evict_valid_i = 0; c_ready_i = 1;
                #1;
                chk($sformatf("rst seq no write k%0d", k), arr_write_en_o, 0);
                if (k < 6) @(posedge clk_i);
            end
            chk("rst seq beat4 word", {c_valid_o, arr_word_sel_o}, {1'b1, 3'd4});
            rst_ni = 0;
            #1;
            chk_reset_vals("mid reset");
            @(posedge clk_i);
            @(negedge clk_i);
            rst_ni = 1; c_ready_i = 0;
            chk("rst seq state kept", mem_state[6][9], 2'd3);
            chk("rst seq write count", wr_count, wr_before);
        end
        run_evict(9, 6, 0, 4, 0, 7, 1, 8, 1, "after reset");

        for (int r = 0; r < 40; r++) begin
            int idx, way;
            idx = $urandom_range(0, 31);
            way = $urandom_range(0, 7);
            mem_state[way][idx] = 2'($urandom_range(0, 3));
            mem_tag[way][idx]   = TAG_W'({$urandom, $urandom});
            spec_msg(mem_state[way][idx], op, prm, nb, dty);
            run_evict(idx, way, $urandom_range(0, 2), $urandom_range(1, 14), bit'($urandom_range(0, 1)),
                      op, prm, nb, dty, $sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
